layer_priority_scheduler: RTL and testbench
===========================================

Name: layer_priority_scheduler

Overview:
- Frame-synchronous arbiter for the VGA object-drawing path.
- Shares one pixel output between four drawing units: each cycle, picks the highest-priority active request and registers its colour.
- Unlike a fixed-priority mux, the priority order and per-layer blink are run-time configurable via a valid/ready handshake. Changes take effect only at frame start.
- Reports a per-frame collision flag between two chosen layers for game logic.

Parameters:
- DEFAULT_ORDER, 8'b11_10_01_00: reset priority order. Slot k is in bits [2k+1:2k]; slot 0 is the highest priority. Each slot holds a layer index 0..3, where index n means input n+1.
- BLINK_FRAMES, 30: frames per blink half-period; legal range 1..255.
- BG_RGB, 8'hFF: RGBOut value when no layer is drawing.
- COLL_A, 0: first layer index for collision detection.
- COLL_B, 1: second layer index for collision detection; must differ from COLL_A.

Ports:
- clk  in  1  system pixel clock
- resetN  in  1  reset
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame
- drawRequest1..drawRequest4  in  1 each  layer draw requests
- RGB1..RGB4  in  8 each  layer colours
- cfgValid  in  1  configuration offered
- cfgOrder  in  8  new priority order
- cfgBlinkMask  in  4  bit n set: layer n blinks
- cfgReady  out  1  scheduler can accept a configuration
- cfgError  out  1  one-cycle pulse: offered order rejected
- drawRequestOut  out  1  registered: some visible layer drew
- RGBOut  out  8  registered pixel colour
- winnerLayer  out  2  registered index of the winning layer
- collision  out  1  COLL_A and COLL_B overlapped during the previous frame

Behaviour:
- Reset is synchronous, active-low; one clock `clk` with synchronous reset `resetN` (active-low).
- Reset values:
  - drawRequestOut = 0, RGBOut = BG_RGB, winnerLayer = 0, collision = 0, cfgError = 0, cfgReady = 1.
  - Active order = DEFAULT_ORDER; active blink mask = 0; blink counter = 0; blinkPhase = 0; sticky collision = 0.
  - State = IDLE; pending registers cleared.
- Reset mid-handshake discards any pending configuration.
- Arbitration (1-cycle latency):
  - Layer n is visible when drawRequest(n+1) = 1 AND NOT (blinkMask[n] AND blinkPhase).
  - Scan slots 0..3; the first slot whose layer is visible wins.
  - On the next edge: drawRequestOut = 1, RGBOut = that layer's RGB, winnerLayer = that index.
  - If no layer is visible: drawRequestOut = 0, RGBOut = BG_RGB, winnerLayer holds its previous value.
- Config state machine:
  - IDLE: cfgReady = 1. On cfgValid = 1, check that cfgOrder is a permutation of {0,1,2,3}.
    - Valid: capture cfgOrder and cfgBlinkMask into pending registers, go to PENDING.
    - Invalid: pulse cfgError next cycle, stay in IDLE, no state change.
  - PENDING: cfgReady = 0. On startOfFrame, copy pending into active order and mask, go to IDLE.
  - Acceptance and startOfFrame in the same cycle: the config waits for the next startOfFrame (applied strictly after acceptance).
  - In the startOfFrame cycle itself, arbitration still uses the old order; the new order governs from the following cycle.
- Blink:
  - On each startOfFrame, the counter increments.
  - When it reaches BLINK_FRAMES-1, it wraps to 0 and blinkPhase toggles. With BLINK_FRAMES = 1, the phase toggles every frame.
  - A blink-mask change does not reset the counter or phase.
- Collision:
  - The sticky flag sets in any cycle where both raw requests COLL_A and COLL_B are 1; raw means blink is ignored.
  - On startOfFrame: collision <= sticky OR current-cycle overlap, and sticky clears.
  - collision therefore holds for one full frame and describes the previous frame.
- All outputs are registered; no combinational input-to-output path.

Decomposition:
- Shared package `vga_layers_pkg`:
  - typedef `layer_idx_t` (2-bit);
  - typedef `prio_order_t` (array of 4 `layer_idx_t`);
  - constant `NUM_LAYERS` = 4;
  - function `is_permutation(prio_order_t)`.
- One sub-module `blink_frame_counter`: frame counter, wrap, and blinkPhase.
- Arbitration, config state machine and collision logic stay in the top module.

Test Plan:
- Reset, then drawRequest3 = 1 with RGB3 = 8'h1C and others 0 → one cycle later drawRequestOut = 1, RGBOut = 8'h1C, winnerLayer = 2. No requests → RGBOut = 8'hFF, drawRequestOut = 0.
- All four requests with RGBs 11/22/33/44; offer cfgOrder = 8'b00_01_10_11 mid-frame → cfgReady drops and output stays 8'h11 until one cycle after the next startOfFrame, then 8'h44. cfgReady returns to 1.
- Offer cfgOrder = 8'b00_00_01_10 → cfgError pulses for one cycle; order unchanged (output stays 8'h11); cfgReady stays 1.
- BLINK_FRAMES = 2, blinkMask = 4'b0001 applied, layers 0 and 1 both drawing (RGB1 = 8'h11, RGB2 = 8'h22) → output alternates 8'h11 / 8'h22 every 2 frames.
- drawRequest1 and drawRequest2 overlap for 1 cycle in frame N → collision = 1 throughout frame N+1, 0 in frame N+2. An overlap coincident with startOfFrame is reported in the next frame.
- Assert resetN = 0 while in PENDING → after release the order is DEFAULT_ORDER and the pending config is never applied at the next startOfFrame.

Source files
------------

// File: rtl/vga_layers_pkg.sv
// Shared types and helpers for the VGA layer drawing path.
package vga_layers_pkg;

    localparam int unsigned NUM_LAYERS = 4;

    typedef logic [1:0] layer_idx_t;
    typedef layer_idx_t [NUM_LAYERS-1:0] prio_order_t;

    // An order is legal when every layer index appears in exactly one slot.
    function automatic logic is_permutation(input prio_order_t order);
        logic [NUM_LAYERS-1:0] seen;
        seen = '0;
        for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
            seen[order[k[1:0]]] = 1'b1;
        end
        return &seen;
    endfunction

endpackage

// File: rtl/blink_frame_counter.sv
// Counts frames and toggles blinkPhase every BLINK_FRAMES frames.
module blink_frame_counter #(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    output logic blinkPhase
);

    localparam logic [7:0] LAST_COUNT = 8'(BLINK_FRAMES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (startOfFrame) begin
            if (cnt_q == LAST_COUNT) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign blinkPhase = phase_q;

endmodule

// File: rtl/layer_priority_scheduler.sv
// Four-layer pixel arbiter with frame-synchronous priority/blink configuration
// and a per-frame collision flag between two chosen layers.
module layer_priority_scheduler
    import vga_layers_pkg::*;
#(
    parameter logic [7:0]  DEFAULT_ORDER = 8'b11_10_01_00,
    parameter int unsigned BLINK_FRAMES  = 30,
    parameter logic [7:0]  BG_RGB        = 8'hFF,
    parameter layer_idx_t  COLL_A        = 2'd0,
    parameter layer_idx_t  COLL_B        = 2'd1
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       drawRequest1,
    input  logic       drawRequest2,
    input  logic       drawRequest3,
    input  logic       drawRequest4,
    input  logic [7:0] RGB1,
    input  logic [7:0] RGB2,
    input  logic [7:0] RGB3,
    input  logic [7:0] RGB4,
    input  logic       cfgValid,
    input  logic [7:0] cfgOrder,
    input  logic [3:0] cfgBlinkMask,
    output logic       cfgReady,
    output logic       cfgError,
    output logic       drawRequestOut,
    output logic [7:0] RGBOut,
    output logic [1:0] winnerLayer,
    output logic       collision
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    logic [0:0]  state_q, state_d;
    prio_order_t order_q, order_d, pend_order_q, pend_order_d;
    logic [3:0]  mask_q, mask_d, pend_mask_q, pend_mask_d;
    logic        sticky_q, sticky_d, coll_q, coll_d;
    logic        dro_q, dro_d, err_q, err_d, rdy_q, rdy_d;
    logic [7:0]  rgb_q, rgb_d;
    layer_idx_t  win_q, win_d;

    logic                  blink_phase;
    logic [NUM_LAYERS-1:0] req, visible;
    logic [7:0]            rgb_arr [NUM_LAYERS];
    logic                  found;

    blink_frame_counter #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .blinkPhase  (blink_phase)
    );

    assign req        = {drawRequest4, drawRequest3, drawRequest2, drawRequest1};
    assign rgb_arr[0] = RGB1;
    assign rgb_arr[1] = RGB2;
    assign rgb_arr[2] = RGB3;
    assign rgb_arr[3] = RGB4;
    assign visible    = req & ~(mask_q & {NUM_LAYERS{blink_phase}});

    always_comb begin
        found = 1'b0;
        dro_d = 1'b0;
        rgb_d = BG_RGB;
        win_d = win_q;
        for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
            if (!found && visible[order_q[k[1:0]]]) begin
                found = 1'b1;
                dro_d = 1'b1;
                rgb_d = rgb_arr[order_q[k[1:0]]];
                win_d = order_q[k[1:0]];
            end
        end
    end

    // A config accepted in a startOfFrame cycle waits for the following frame.
    always_comb begin
        state_d      = state_q;
        order_d      = order_q;
        mask_d       = mask_q;
        pend_order_d = pend_order_q;
        pend_mask_d  = pend_mask_q;
        err_d        = 1'b0;
        if (state_q == ST_IDLE) begin
            if (cfgValid) begin
                if (is_permutation(prio_order_t'(cfgOrder))) begin
                    pend_order_d = prio_order_t'(cfgOrder);
                    pend_mask_d  = cfgBlinkMask;
                    state_d      = ST_PENDING;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (startOfFrame) begin
            order_d = pend_order_q;
            mask_d  = pend_mask_q;
            state_d = ST_IDLE;
        end
        rdy_d = (state_d == ST_IDLE);
    end

    always_comb begin
        sticky_d = sticky_q | (req[COLL_A] & req[COLL_B]);
        coll_d   = coll_q;
        if (startOfFrame) begin
            coll_d   = sticky_d;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q      <= ST_IDLE;
            order_q      <= prio_order_t'(DEFAULT_ORDER);
            mask_q       <= '0;
            pend_order_q <= '0;
            pend_mask_q  <= '0;
            sticky_q     <= 1'b0;
            coll_q       <= 1'b0;
            dro_q        <= 1'b0;
            rgb_q        <= BG_RGB;
            win_q        <= '0;
            err_q        <= 1'b0;
            rdy_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            order_q      <= order_d;
            mask_q       <= mask_d;
            pend_order_q <= pend_order_d;
            pend_mask_q  <= pend_mask_d;
            sticky_q     <= sticky_d;
            coll_q       <= coll_d;
            dro_q        <= dro_d;
            rgb_q        <= rgb_d;
            win_q        <= win_d;
            err_q        <= err_d;
            rdy_q        <= rdy_d;
        end
    end

    assign cfgReady       = rdy_q;
    assign cfgError       = err_q;
    assign drawRequestOut = dro_q;
    assign RGBOut         = rgb_q;
    assign winnerLayer    = win_q;
    assign collision      = coll_q;

endmodule

// File: tb/tb_layer_priority_scheduler.sv
// Scoreboard bench: a frame-level reference model predicts every output cycle.
module tb_layer_priority_scheduler;

    localparam int BF = 2;

    logic       clk;
    logic       resetN, startOfFrame;
    logic       drawRequest1, drawRequest2, drawRequest3, drawRequest4;
    logic [7:0] RGB1, RGB2, RGB3, RGB4;
    logic       cfgValid;
    logic [7:0] cfgOrder;
    logic [3:0] cfgBlinkMask;
    logic       cfgReady, cfgError, drawRequestOut, collision;
    logic [7:0] RGBOut;
    logic [1:0] winnerLayer;

    layer_priority_scheduler #(
        .DEFAULT_ORDER(8'b11_10_01_00),
        .BLINK_FRAMES (BF),
        .BG_RGB       (8'hFF),
        .COLL_A       (2'd0),
        .COLL_B       (2'd1)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .drawRequest1  (drawRequest1),
        .drawRequest2  (drawRequest2),
        .drawRequest3  (drawRequest3),
        .drawRequest4  (drawRequest4),
        .RGB1          (RGB1),
        .RGB2          (RGB2),
        .RGB3          (RGB3),
        .RGB4          (RGB4),
        .cfgValid      (cfgValid),
        .cfgOrder      (cfgOrder),
        .cfgBlinkMask  (cfgBlinkMask),
        .cfgReady      (cfgReady),
        .cfgError      (cfgError),
        .drawRequestOut(drawRequestOut),
        .RGBOut        (RGBOut),
        .winnerLayer   (winnerLayer),
        .collision     (collision)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       dro;
        logic [7:0] rgb;
        logic [1:0] win;
        logic       coll;
        logic       err;
        logic       rdy;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // stimulus state
    bit         s_rst_n   = 1'b0;
    bit   [3:0] s_req     = '0;
    logic [7:0] s_rgb [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    bit         s_cv      = 1'b0;
    logic [7:0] s_co      = '0;
    logic [3:0] s_cm      = '0;
    int         frame_len = 12;
    int         frame_pos = 0;
    bit         rand_sof  = 1'b0;

    // reference model state
    int         m_order [4];
    bit   [3:0] m_mask;
    int         m_sofs;
    bit         m_pend;
    int         p_order [4];
    bit   [3:0] p_mask;
    bit         m_frame_ovl;
    bit         m_coll;
    int         m_win;

    function automatic bit legal_order(input logic [7:0] o);
        int cnt [4] = '{0, 0, 0, 0};
        for (int k = 0; k < 4; k++) cnt[o[2*k +: 2]]++;
        return cnt[0] == 1 && cnt[1] == 1 && cnt[2] == 1 && cnt[3] == 1;
    endfunction

    function automatic void model(input bit sof, output exp_t e);
        bit phase, ovl, found;
        e = '{dro: 1'b0, rgb: 8'hFF, win: 2'd0, coll: 1'b0, err: 1'b0, rdy: 1'b1};
        if (!s_rst_n) begin
            for (int k = 0; k < 4; k++) m_order[k] = k;
            m_mask = '0; m_sofs = 0; m_pend = 0; m_frame_ovl = 0; m_coll = 0; m_win = 0;
            return;
        end
        phase = ((m_sofs / BF) % 2) == 1;
        found = 0;
        for (int k = 0; k < 4; k++) begin
            int l = m_order[k];
            if (!found && s_req[l] && !(m_mask[l] && phase)) begin
                found = 1;
                m_win = l;
                e.dro = 1'b1;
                e.rgb = s_rgb[l];
            end
        end
        e.win = 2'(m_win);
        ovl = s_req[0] && s_req[1];
        if (sof) begin
            m_coll = m_frame_ovl || ovl;
            m_frame_ovl = 0;
            m_sofs++;
        end else begin
            m_frame_ovl = m_frame_ovl || ovl;
        end
        if (m_pend) begin
            if (sof) begin
                m_order = p_order;
                m_mask  = p_mask;
                m_pend  = 0;
            end
        end else if (s_cv) begin
            if (legal_order(s_co)) begin
                for (int k = 0; k < 4; k++) p_order[k] = int'(s_co[2*k +: 2]);
                p_mask = s_cm;
                m_pend = 1;
            end else begin
                e.err = 1'b1;
            end
        end
        e.coll = m_coll;
        e.rdy  = !m_pend;
    endfunction

    task automatic cycle();
        bit   sof;
        exp_t e;
        @(negedge clk);
        if (rand_sof) sof = ($urandom_range(0, 9) == 0);
        else          sof = (frame_pos == 0);
        frame_pos = (frame_pos + 1 >= frame_len) ? 0 : frame_pos + 1;
        resetN       = s_rst_n;
        startOfFrame = sof;
        drawRequest1 = s_req[0];
        drawRequest2 = s_req[1];
        drawRequest3 = s_req[2];
        drawRequest4 = s_req[3];
        RGB1 = s_rgb[0]; RGB2 = s_rgb[1]; RGB3 = s_rgb[2]; RGB4 = s_rgb[3];
        cfgValid     = s_cv;
        cfgOrder     = s_co;
        cfgBlinkMask = s_cm;
        model(sof, e);
        sb_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic offer(input logic [7:0] order, input logic [3:0] mask);
        s_cv = 1'b1; s_co = order; s_cm = mask;
        cycle();
        s_cv = 1'b0;
    endtask

    task automatic align_frame();
        while (frame_pos != 0) cycle();
    endtask

    // monitor: one output sample per clock, compared against the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_tests++;
                if (drawRequestOut !== e.dro || RGBOut !== e.rgb || winnerLayer !== e.win ||
                    collision !== e.coll || cfgError !== e.err || cfgReady !== e.rdy) begin
                    n_fail++;
                    $display("FAIL pixel_out t=%0t: got dro=%0b rgb=%h win=%0d coll=%0b err=%0b rdy=%0b, want dro=%0b rgb=%h win=%0d coll=%0b err=%0b rdy=%0b",
                             $time, drawRequestOut, RGBOut, winnerLayer, collision, cfgError, cfgReady,
                             e.dro, e.rgb, e.win, e.coll, e.err, e.rdy);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset and basic single-layer / background behaviour
        s_rst_n = 1'b0;
        run(3);
        s_rst_n = 1'b1;
        run(2);
        s_req = 4'b0100; s_rgb[2] = 8'h1C;
        run(3);
        s_req = 4'b0000;
        run(3);

        // reorder mid-frame: takes effect one cycle after the next frame start
        align_frame();
        s_req = 4'b1111;
        s_rgb = '{8'h11, 8'h22, 8'h33, 8'h44};
        run(4);
        offer(8'b00_01_10_11, 4'b0000);
        run(2 * frame_len);

        // restore default order, then offer an illegal order
        offer(8'b11_10_01_00, 4'b0000);
        run(frame_len + 2);
        offer(8'b00_00_01_10, 4'b1111);
        run(frame_len + 2);

        // blink layer 0 over layers 0 and 1
        s_req = 4'b0011;
        offer(8'b11_10_01_00, 4'b0001);
        run(9 * frame_len);
        offer(8'b11_10_01_00, 4'b0000);
        run(frame_len + 1);

        // collision: single overlap mid-frame, then overlap on frame start
        align_frame();
        s_req = 4'b0001;
        run(5);
        s_req = 4'b0011; cycle();
        s_req = 4'b0001;
        align_frame();
        run(2 * frame_len);
        s_req = 4'b0011; cycle();
        s_req = 4'b0001;
        run(2 * frame_len);

        // reset while a configuration is pending
        s_req = 4'b1111;
        run(3);
        offer(8'b00_01_10_11, 4'b0001);
        run(2);
        s_rst_n = 1'b0;
        run(2);
        s_rst_n = 1'b1;
        run(3 * frame_len);

        // randomized traffic
        rand_sof = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            s_req = 4'($urandom);
            for (int k = 0; k < 4; k++) s_rgb[k] = 8'($urandom);
            s_rst_n = ($urandom_range(0, 399) != 0);
            s_cv = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 1) == 1) begin
                int a [4] = '{0, 1, 2, 3};
                for (int k = 3; k > 0; k--) begin
                    int j = $urandom_range(0, k);
                    int t = a[k];
                    a[k] = a[j];
                    a[j] = t;
                end
                s_co = {2'(a[3]), 2'(a[2]), 2'(a[1]), 2'(a[0])};
            end else begin
                s_co = 8'($urandom);
            end
            s_cm = 4'($urandom);
            cycle();
        end
        s_cv = 1'b0;
        s_rst_n = 1'b1;
        run(2);

        @(posedge clk);
        #3;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
